// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX byte arbiter.
// Optional grant statistics are enabled with UART_ARB_STATS_EN.
package uart_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 8;
  localparam int CNT_W    = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic int wrap_inc(
    input int i,
    input int n
  );
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Scans upward from ptr with wrap; first eligible index wins.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         elig,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  int j;

  // first eligible requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && elig[j]) begin
        found = 1'b1;
        idx   = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding single bytes into a UART TX FIFO.
// Define UART_ARB_STATS_EN to add per-requester grant counters.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    en_mask,
  input  logic               tx_full,
  output logic               wr_uart,
  output logic [DW-1:0]      w_data,
  output logic [NREQ-1:0]    gnt,
  output logic               busy
`ifdef UART_ARB_STATS_EN
  ,
  input  logic                  cnt_clr,
  output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = 1;

  arb_state_t state_q;
  arb_state_t state_d;

  logic [IW-1:0]   ptr_q;
  logic [NREQ-1:0] elig;
  logic            found;
  logic [IW-1:0]   win;
  logic            take;

  assign elig = req & en_mask;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .elig  (elig),
    .ptr   (ptr_q),
    .found (found),
    .idx   (win)
  );

  // next state; a grant lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    wr_uart = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found && !tx_full) begin
          take    = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        wr_uart = 1'b1;
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // latch winner byte, one-hot grant and advance pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      w_data <= '0;
      gnt    <= '0;
      ptr_q  <= '0;
    end else begin
      gnt <= '0;
      if (take) begin
        w_data <= req_data[int'(win)*DW +: DW];
        gnt    <= ONE << win;
        ptr_q  <= IW'(wrap_inc(int'(win), NREQ));
      end
    end
  end

`ifdef UART_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NREQ];

  // saturating grant counters; clear beats increment
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst || cnt_clr)
        cnt_q[i] <= '0;
      else if (gnt[i] && cnt_q[i] != CNT_MAX)
        cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter.
// Stats scenario is built only with UART_ARB_STATS_EN.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  en_mask = 4'hF;
  logic        tx_full = 1'b0;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic [3:0]  gnt;
  logic        busy;
`ifdef UART_ARB_STATS_EN
  logic        cnt_clr = 1'b0;
  logic [63:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  bit         m_busy = 1'b0;
  int         m_ptr = 0;
  bit         e_wr = 1'b0;
  bit         e_busy = 1'b0;
  logic [3:0] e_gnt = '0;
  logic [7:0] e_data = '0;

  uart_tx_arbiter #(
    .NREQ (4),
    .DW   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .en_mask   (en_mask),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .w_data    (w_data),
    .gnt       (gnt),
    .busy      (busy)
`ifdef UART_ARB_STATS_EN
    ,
    .cnt_clr   (cnt_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // one clock; the model applies the arbitration rules to the sampled inputs
  task automatic tick();
    logic [3:0] el;
    int w;
    @(posedge clk);
    el = req & en_mask;
    if (rst) begin
      m_busy = 1'b0;
      e_gnt  = '0;
      e_data = '0;
      m_ptr  = 0;
    end else if (m_busy) begin
      m_busy = 1'b0;
      e_gnt  = '0;
    end else if (el != 0 && !tx_full) begin
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && el[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      m_busy = 1'b1;
      e_data = req_data[w*8 +: 8];
      e_gnt  = 4'b0001 << w;
      m_ptr  = (w + 1) % 4;
    end else begin
      e_gnt = '0;
    end
    e_wr   = m_busy;
    e_busy = m_busy;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = '0;
    do_reset();
    checks++;
    if ({wr_uart, busy, gnt, w_data} !== 14'd0) begin
      errors++;
      $display("FAIL reset: wr=%b busy=%b gnt=%b data=%h, want all zero",
               wr_uart, busy, gnt, w_data);
    end
  endtask

  task automatic test_single();
    req_data = 32'd94;
    req = 4'b0001;
    tick();
    checks++;
    if (wr_uart !== 1'b1 || w_data !== 8'd94 || gnt !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single: wr=%b data=%0d gnt=%b busy=%b, want 1 94 0001 1",
               wr_uart, w_data, gnt, busy);
    end
    req = '0;
    tick();
    checks++;
    if (wr_uart !== 1'b0 || gnt !== 4'b0000 || w_data !== 8'd94) begin
      errors++;
      $display("FAIL single_end: wr=%b gnt=%b data=%0d, want 0 0000 94",
               wr_uart, gnt, w_data);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] got[$];
    logic [7:0] want [5];
    want = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    do_reset();
    req_data = 32'h13121110;
    req = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (wr_uart !== (k % 2 == 0)) begin
        errors++;
        $display("FAIL rr_rate cyc%0d: wr=%b, want %b", k, wr_uart, (k % 2 == 0));
      end
      if (wr_uart === 1'b1) got.push_back(w_data);
    end
    req = '0;
    tick();
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL rr_count: %0d writes, want 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] !== want[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %h, want %h", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_tx_full();
    req_data = 32'h005A0000;
    req = 4'b0100;
    tx_full = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (wr_uart !== 1'b0 || gnt !== 4'b0000) begin
        errors++;
        $display("FAIL full_hold cyc%0d: wr=%b gnt=%b, want 0 0000", k, wr_uart, gnt);
      end
    end
    tx_full = 1'b0;
    tick();
    checks++;
    if (wr_uart !== 1'b1 || gnt !== 4'b0100 || w_data !== 8'h5A) begin
      errors++;
      $display("FAIL full_release: wr=%b gnt=%b data=%h, want 1 0100 5a",
               wr_uart, gnt, w_data);
    end
    req = '0;
    tick();
    checks++;
    if (wr_uart !== 1'b0 || w_data !== 8'h5A) begin
      errors++;
      $display("FAIL full_idle: wr=%b data=%h, want 0 5a", wr_uart, w_data);
    end
  endtask

  task automatic test_mask();
    int got[$];
    int want [4];
    want = '{0, 1, 3, 0};
    do_reset();
    en_mask = 4'b1011;
    req = 4'b1111;
    req_data = 32'h44332211;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (gnt[2] !== 1'b0) begin
        errors++;
        $display("FAIL mask_gnt2 cyc%0d: gnt=%b, want bit2 clear", k, gnt);
      end
      for (int i = 0; i < 4; i++) if (gnt[i] === 1'b1) got.push_back(i);
    end
    req = '0;
    en_mask = 4'hF;
    tick();
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL mask_count: %0d grants, want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] != want[i]) begin
          errors++;
          $display("FAIL mask_order[%0d]: got %0d, want %0d", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_grant_freeze();
    do_reset();
    req_data = 32'h00000033;
    req = 4'b0001;
    tick();
    req_data = 32'hFFFFFFFF;
    req = 4'b1111;
    tx_full = 1'b1;
    #2;
    tx_full = 1'b0;
    tick();
    checks++;
    if (wr_uart !== 1'b0 || gnt !== 4'b0000 || w_data !== 8'h33) begin
      errors++;
      $display("FAIL freeze_gap: wr=%b gnt=%b data=%h, want 0 0000 33",
               wr_uart, gnt, w_data);
    end
    tick();
    checks++;
    if (wr_uart !== 1'b1 || gnt !== 4'b0010 || w_data !== 8'hFF) begin
      errors++;
      $display("FAIL freeze_next: wr=%b gnt=%b data=%h, want 1 0010 ff",
               wr_uart, gnt, w_data);
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_in_grant();
    do_reset();
    req_data = 32'h0000AB00;
    req = 4'b0010;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL rig_grant: gnt=%b, want 0010", gnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (wr_uart !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0 || w_data !== 8'h00) begin
      errors++;
      $display("FAIL rig_abort: wr=%b gnt=%b busy=%b data=%h, want 0 0000 0 00",
               wr_uart, gnt, busy, w_data);
    end
    req = 4'b1111;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL rig_ptr: gnt=%b, want 0001", gnt);
    end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req      = 4'($urandom);
      en_mask  = 4'($urandom);
      req_data = $urandom;
      tx_full  = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 39) == 0);
      tick();
      checks++;
      if ({wr_uart, busy, gnt, w_data} !== {e_wr, e_busy, e_gnt, e_data}) begin
        errors++;
        $display("FAIL rand cyc%0d: wr=%b busy=%b gnt=%b data=%h, want %b %b %b %h",
                 k, wr_uart, busy, gnt, w_data, e_wr, e_busy, e_gnt, e_data);
      end
    end
    rst = 1'b0;
    req = '0;
    en_mask = 4'hF;
    tx_full = 1'b0;
    tick();
  endtask

`ifdef UART_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    req_data = 32'h00000100;
    req = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) req = '0;
      tick();
    end
    checks++;
    if (grant_cnt[31:16] !== 16'd3 || grant_cnt[15:0] !== 16'd0) begin
      errors++;
      $display("FAIL stats_cnt: cnt1=%0d cnt0=%0d, want 3 0",
               grant_cnt[31:16], grant_cnt[15:0]);
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (grant_cnt !== 64'd0) begin
      errors++;
      $display("FAIL stats_clr: cnt=%h, want 0", grant_cnt);
    end
    dut.cnt_q[1] = 16'hFFFF;
    req = 4'b0010;
    tick();
    req = '0;
    tick();
    checks++;
    if (grant_cnt[31:16] !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_sat: cnt1=%h, want ffff", grant_cnt[31:16]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_tx_full();
    test_mask();
    test_grant_freeze();
    test_reset_in_grant();
    test_random();
`ifdef UART_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
